rate_detector: RTL and testbench

Measures the spacing between strobe events on a single input and classifies it into the same 2-bit rate code used for the board's rate selection (00 = every cycle, 01 ≈ 1 s, 10 ≈ 2 s, 11 ≈ 4 s at 50 MHz). It is the receive-side counterpart of the rate divider: it reconstructs the divider's `SW[1:0]` setting from its enable pulse train (or any external strobe). Outputs feed the LEDR/HEX display path and the top-level status logic.

---
 rtl/rate_detector.sv | 196 +++++++++++++++++++
 tb/tb_rate_detector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_detector.sv
// -----------------------------------------------------------------------------
// rate_detector
//
// Measures the spacing between strobe events on pulse_in and classifies it
// into the 2-bit board rate code (00 = every cycle, 01 ~ 1 s, 10 ~ 2 s,
// 11 ~ 4 s at 50 MHz). This is the receive-side counterpart of the rate
// divider: it rebuilds the divider setting from its enable pulse train.
//
// Optional feature macro: RATE_DETECTOR_SYNC_EN
//   defined   -> pulse_in passes through a 2-flop synchronizer; the event is
//                seen 2 cycles late and every output latency grows by 2.
//   undefined -> pulse_in is used directly and must be synchronous to Clock.
//
// Ports:
//   Clock        in   1      single clock, all state on the rising edge
//   reset_n      in   1      asynchronous active-low reset
//   pulse_in     in   1      event strobe, every cycle sampled high is an event
//   rate         out  2      last classified rate code
//   period       out  CNT_W  last measured interval in cycles
//   valid        out  1      one-cycle pulse: new rate/period loaded
//   rate_change  out  1      one-cycle pulse with valid when the code changed
//   locked       out  1      high while measurements are current
//   lost         out  1      one-cycle pulse when the interval hits TIMEOUT
// -----------------------------------------------------------------------------
module rate_detector #(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned TH1     = 25_000_000,
    parameter int unsigned TH2     = 75_000_000,
    parameter int unsigned TH3     = 150_000_000,
    parameter int unsigned TIMEOUT = 250_000_000
) (
    input  logic             Clock,
    input  logic             reset_n,
    input  logic             pulse_in,
    output logic [1:0]       rate,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             rate_change,
    output logic             locked,
    output logic             lost
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_MEASURE = 2'b01,
        S_LOST    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_TH1     = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] C_TH2     = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] C_TH3     = CNT_W'(TH3);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    // Map a measured interval onto the board rate code.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
        logic [1:0] code;
        if (p < C_TH1) begin
            code = 2'b00;
        end else if (p < C_TH2) begin
            code = 2'b01;
        end else if (p < C_TH3) begin
            code = 2'b10;
        end else begin
            code = 2'b11;
        end
        return code;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rate;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_rate_change;
    logic             r_locked;
    logic             r_lost;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_rate_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_valid_nxt;
    logic             w_rate_change_nxt;
    logic             w_locked_nxt;
    logic             w_lost_nxt;
    logic [1:0]       w_code;
    logic             w_ev;

`ifdef RATE_DETECTOR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for asynchronous strobe sources.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ev = r_sync2;
`else
    assign w_ev = pulse_in;
`endif

    assign w_code = classify(r_cnt);

    // State, interval counter and registered outputs.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= C_ZERO;
            r_rate        <= 2'b00;
            r_period      <= C_ZERO;
            r_valid       <= 1'b0;
            r_rate_change <= 1'b0;
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rate        <= w_rate_nxt;
            r_period      <= w_period_nxt;
            r_valid       <= w_valid_nxt;
            r_rate_change <= w_rate_change_nxt;
            r_locked      <= w_locked_nxt;
            r_lost        <= w_lost_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, the rest hold.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_rate_nxt        = r_rate;
        w_period_nxt      = r_period;
        w_valid_nxt       = 1'b0;
        w_rate_change_nxt = 1'b0;
        w_locked_nxt      = r_locked;
        w_lost_nxt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MEASURE: begin
                // An event on the TIMEOUT cycle is still a valid measurement.
                if (w_ev) begin
                    w_period_nxt      = r_cnt;
                    w_rate_nxt        = w_code;
                    w_valid_nxt       = 1'b1;
                    w_rate_change_nxt = (w_code != r_rate);
                    w_locked_nxt      = 1'b1;
                    w_cnt_nxt         = C_ONE;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt  = S_LOST;
                    w_locked_nxt = 1'b0;
                    w_lost_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_LOST: begin
                // First event after a loss only re-arms the counter.
                if (w_ev) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_state_nxt = S_LOST;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = C_ZERO;
                w_locked_nxt = 1'b0;
            end
        endcase
    end

    assign rate        = r_rate;
    assign period      = r_period;
    assign valid       = r_valid;
    assign rate_change = r_rate_change;
    assign locked      = r_locked;
    assign lost        = r_lost;

endmodule

// File: tb/tb_rate_detector.sv
// -----------------------------------------------------------------------------
// Self-checking directed bench for rate_detector (CNT_W=6, TH1=4, TH2=8,
// TH3=16, TIMEOUT=32). Inputs change and outputs are sampled 1 ns after the
// rising edge. LAT absorbs the extra synchronizer delay when
// RATE_DETECTOR_SYNC_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rate_detector;

`ifdef RATE_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       pulse_in;
    logic [1:0] rate;
    logic [5:0] period;
    logic       valid;
    logic       rate_change;
    logic       locked;
    logic       lost;

    int checks;
    int failures;

    rate_detector #(
        .CNT_W(6), .TH1(4), .TH2(8), .TH3(16), .TIMEOUT(32)
    ) dut (
        .Clock(clk),
        .reset_n(reset_n),
        .pulse_in(pulse_in),
        .rate(rate),
        .period(period),
        .valid(valid),
        .rate_change(rate_change),
        .locked(locked),
        .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    // One-cycle strobe, then wait until its effect is visible on the outputs.
    task automatic fire();
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        repeat (LAT) step();
    endtask

    // Complete one interval of p cycles since the previous fire and check
    // the resulting measurement.
    task automatic interval(input int p, input logic [1:0] exp_rate,
                            input logic exp_rc, input string nm);
        pulse_in = 1'b0;
        if (p - 1 - LAT >= 1) begin
            step();
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_gap_valid got=%0b exp=0", nm, valid);
            end
            repeat (p - 2 - LAT) step();
        end
        fire();
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got=%0b exp=1", nm, valid);
        end
        checks++;
        if (period !== 6'(p)) begin
            failures++;
            $display("FAIL %s_period got=%0d exp=%0d", nm, period, p);
        end
        checks++;
        if (rate !== exp_rate) begin
            failures++;
            $display("FAIL %s_rate got=%b exp=%b", nm, rate, exp_rate);
        end
        checks++;
        if (rate_change !== exp_rc) begin
            failures++;
            $display("FAIL %s_rate_change got=%0b exp=%0b", nm, rate_change, exp_rc);
        end
        checks++;
        if (locked !== 1'b1 || lost !== 1'b0) begin
            failures++;
            $display("FAIL %s_locked_lost got=%0b%0b exp=10", nm, locked, lost);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rate, period, valid, rate_change, locked, lost} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%0d_%b%b%b%b exp=00_0_0000",
                     rate, period, valid, rate_change, locked, lost);
        end
    endtask

    task automatic test_held_high();
        int vcount;
        int rccount;
        do_reset();
        pulse_in = 1'b1;
        step();
        repeat (LAT) step();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL held_first_edge_valid got=%0b exp=0", valid);
        end
        step();
        checks++;
        if ({valid, rate, period, locked, rate_change} !== {1'b1, 2'b00, 6'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL held_first_meas got=v%0b r%b p%0d l%0b rc%0b exp=v1 r00 p1 l1 rc0",
                     valid, rate, period, locked, rate_change);
        end
        vcount  = 0;
        rccount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid === 1'b1 && period === 6'd1) vcount++;
            if (rate_change !== 1'b0) rccount++;
        end
        checks++;
        if (vcount !== 8 || rccount !== 0) begin
            failures++;
            $display("FAIL held_every_cycle got=valid%0d rc%0d exp=valid8 rc0", vcount, rccount);
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_rates();
        do_reset();
        fire();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rates_arm_valid got=%0b exp=0", valid);
        end
        interval(5,  2'b01, 1'b1, "rate5a");
        interval(5,  2'b01, 1'b0, "rate5b");
        interval(10, 2'b10, 1'b1, "rate10a");
        interval(10, 2'b10, 1'b0, "rate10b");
        interval(20, 2'b11, 1'b1, "rate20a");
        interval(20, 2'b11, 1'b0, "rate20b");
    endtask

    task automatic test_boundaries();
        do_reset();
        fire();
        interval(3,  2'b00, 1'b0, "bnd3");
        interval(4,  2'b01, 1'b1, "bnd4");
        interval(7,  2'b01, 1'b0, "bnd7");
        interval(8,  2'b10, 1'b1, "bnd8");
        interval(15, 2'b10, 1'b0, "bnd15");
        interval(16, 2'b11, 1'b1, "bnd16");
    endtask

    task automatic test_lost();
        int early;
        do_reset();
        fire();
        interval(5, 2'b01, 1'b1, "lost_pre");
        early = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            if (lost !== 1'b0 || locked !== 1'b1) early++;
        end
        checks++;
        if (early !== 0) begin
            failures++;
            $display("FAIL lost_early got=%0d exp=0", early);
        end
        step();
        checks++;
        if ({lost, locked, valid, rate, period} !== {1'b1, 1'b0, 1'b0, 2'b01, 6'd5}) begin
            failures++;
            $display("FAIL lost_pulse got=lost%0b l%0b v%0b r%b p%0d exp=lost1 l0 v0 r01 p5",
                     lost, locked, valid, rate, period);
        end
        step();
        checks++;
        if (lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_width got=%0b exp=0", lost);
        end
        repeat (6) step();
        fire();
        checks++;
        if (valid !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL lost_rearm got=v%0b l%0b exp=v0 l0", valid, locked);
        end
        interval(6, 2'b01, 1'b0, "lost_relock");
    endtask

    task automatic test_timeout_exact();
        do_reset();
        fire();
        interval(32, 2'b11, 1'b1, "tmo32");
        step();
        checks++;
        if (lost !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo32_after got=lost%0b v%0b exp=lost0 v0", lost, valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fire();
        interval(5, 2'b01, 1'b1, "arst_pre");
        repeat (11) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rate, period, valid, rate_change, locked, lost} !== 12'h000) begin
            failures++;
            $display("FAIL async_reset got=%b_%0d_%b%b%b%b exp=00_0_0000",
                     rate, period, valid, rate_change, locked, lost);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        fire();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_rearm got=%0b exp=0", valid);
        end
        interval(4, 2'b01, 1'b1, "arst_post");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        pulse_in = 1'b0;
        test_reset();
        test_held_high();
        test_rates();
        test_boundaries();
        test_lost();
        test_timeout_exact();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
